// File: rtl/riscv_pkg.sv
// Shared ALU operation encodings and decode helpers for the ALU control pipe.
package riscv_pkg;

  localparam int ALUOP_WIDTH = 5;
  typedef logic [ALUOP_WIDTH-1:0] aluop_t;

  // Zero is reserved for "no operation": it appears on bubbles and illegal results.
  localparam aluop_t NOP_OP    = 5'd0;
  localparam aluop_t ADD_OP    = 5'd1;
  localparam aluop_t SUB_OP    = 5'd2;
  localparam aluop_t SLL_OP    = 5'd3;
  localparam aluop_t SLT_OP    = 5'd4;
  localparam aluop_t SLTU_OP   = 5'd5;
  localparam aluop_t XOR_OP    = 5'd6;
  localparam aluop_t SRL_OP    = 5'd7;
  localparam aluop_t SRA_OP    = 5'd8;
  localparam aluop_t OR_OP     = 5'd9;
  localparam aluop_t AND_OP    = 5'd10;
  localparam aluop_t PASS_OP   = 5'd11;
  localparam aluop_t MUL_OP    = 5'd12;
  localparam aluop_t MULH_OP   = 5'd13;
  localparam aluop_t MULHSU_OP = 5'd14;
  localparam aluop_t MULHU_OP  = 5'd15;
  localparam aluop_t DIV_OP    = 5'd16;
  localparam aluop_t DIVU_OP   = 5'd17;
  localparam aluop_t REM_OP    = 5'd18;
  localparam aluop_t REMU_OP   = 5'd19;

  localparam logic [1:0] ALUCTRL_ADD   = 2'b00;
  localparam logic [1:0] ALUCTRL_SUB   = 2'b01;
  localparam logic [1:0] ALUCTRL_FUNCT = 2'b10;
  localparam logic [1:0] ALUCTRL_PASS  = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [2:0] F3_SR = 3'b101;

  // Base integer op selected by funct3 (funct7 = 0000000).
  function automatic aluop_t base_op(input logic [2:0] f3);
    aluop_t op;
    op = NOP_OP;
    unique case (f3)
      3'b000: op = ADD_OP;
      3'b001: op = SLL_OP;
      3'b010: op = SLT_OP;
      3'b011: op = SLTU_OP;
      3'b100: op = XOR_OP;
      3'b101: op = SRL_OP;
      3'b110: op = OR_OP;
      3'b111: op = AND_OP;
    endcase
    return op;
  endfunction

  // RV32M op selected by funct3 (funct7 = 0000001).
  function automatic aluop_t mext_op(input logic [2:0] f3);
    aluop_t op;
    op = NOP_OP;
    unique case (f3)
      3'b000: op = MUL_OP;
      3'b001: op = MULH_OP;
      3'b010: op = MULHSU_OP;
      3'b011: op = MULHU_OP;
      3'b100: op = DIV_OP;
      3'b101: op = DIVU_OP;
      3'b110: op = REM_OP;
      3'b111: op = REMU_OP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control decode: ALUctrl/funct3/funct7 -> operation code.
module alu_op_decode
  import riscv_pkg::*;
#(
  parameter int M_EXT     = 0,
  parameter int STRICT_F7 = 1
) (
  input  logic [1:0] i_ALUctrl,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output aluop_t     o_ALUOp,
  output logic       o_is_mext,
  output logic       o_illegal
);

  // Decode; an illegal request always reports NOP_OP with is_mext clear.
  always_comb begin
    o_ALUOp   = NOP_OP;
    o_is_mext = 1'b0;
    o_illegal = 1'b0;
    unique case (i_ALUctrl)
      ALUCTRL_ADD:  o_ALUOp = ADD_OP;
      ALUCTRL_SUB:  o_ALUOp = SUB_OP;
      ALUCTRL_PASS: o_ALUOp = PASS_OP;
      ALUCTRL_FUNCT: begin
        if (i_funct7 == F7_BASE) begin
          o_ALUOp = base_op(i_funct3);
        end else if (i_funct7 == F7_ALT) begin
          o_ALUOp = (i_funct3 == F3_SR) ? SRA_OP : base_op(i_funct3);
        end else if ((i_funct7 == F7_MEXT) && (M_EXT != 0)) begin
          o_ALUOp   = mext_op(i_funct3);
          o_is_mext = 1'b1;
        end else if (STRICT_F7 != 0) begin
          o_illegal = 1'b1;
        end else begin
          // Lenient mode: treat unknown funct7 like the base encoding, but keep
          // the arithmetic right shift so SRAI-like encodings still work.
          o_ALUOp = (i_funct3 == F3_SR) ? SRA_OP : base_op(i_funct3);
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_control_pipe.sv
// Pipelined, thread-tagged ALU control decode with a saturating illegal-op counter.
//
// Handshake: there is no backpressure. A request is accepted on any rising edge
// where i_valid=1 and i_stall=0; it emerges PIPE_STAGES unstalled edges later with
// its own thread tag. i_stall freezes all stages and drops the inputs of that cycle.
module alu_control_pipe
  import riscv_pkg::*;
#(
  parameter int NUM_THREADS = 16,
  parameter int PIPE_STAGES = 1,
  parameter int M_EXT       = 0,
  parameter int STRICT_F7   = 1,
  localparam int TID_W      = $clog2(NUM_THREADS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [TID_W-1:0] i_thread_id,
  input  logic [1:0]       i_ALUctrl,
  input  logic [2:0]       i_funct3,
  input  logic [6:0]       i_funct7,
  input  logic             i_stall,
  input  logic             i_cnt_clr,
  output logic             o_valid,
  output logic [TID_W-1:0] o_thread_id,
  output aluop_t           o_ALUOp,
  output logic             o_is_mext,
  output logic             o_illegal,
  output logic [15:0]      o_illegal_cnt
);

  typedef struct packed {
    logic             valid;
    logic [TID_W-1:0] tid;
    aluop_t           op;
    logic             is_mext;
    logic             illegal;
  } stage_t;

  aluop_t dec_op;
  logic   dec_mext;
  logic   dec_illegal;

  stage_t in_s;
  stage_t last_next_s;
  stage_t stage_q [PIPE_STAGES];

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  alu_op_decode #(
    .M_EXT     (M_EXT),
    .STRICT_F7 (STRICT_F7)
  ) u_dec (
    .i_ALUctrl (i_ALUctrl),
    .i_funct3  (i_funct3),
    .i_funct7  (i_funct7),
    .o_ALUOp   (dec_op),
    .o_is_mext (dec_mext),
    .o_illegal (dec_illegal)
  );

  // Build the stage-0 payload; bubbles carry all-zero fields.
  always_comb begin
    in_s = '0;
    if (i_valid) begin
      in_s.valid   = 1'b1;
      in_s.tid     = i_thread_id;
      in_s.op      = dec_op;
      in_s.is_mext = dec_mext;
      in_s.illegal = dec_illegal;
    end
  end

  // The entry that will be on the outputs after the next unstalled edge.
  if (PIPE_STAGES == 1) begin : g_next_single
    assign last_next_s = in_s;
  end else begin : g_next_multi
    assign last_next_s = stage_q[PIPE_STAGES-2];
  end

  // Stage registers: advance together when not stalled, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else if (!i_stall) begin
      stage_q[0] <= in_s;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Counter next state: clear wins over stall; count on an illegal result becoming visible.
  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (!i_stall && last_next_s.valid && last_next_s.illegal && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_valid       = stage_q[PIPE_STAGES-1].valid;
  assign o_thread_id   = stage_q[PIPE_STAGES-1].tid;
  assign o_ALUOp       = stage_q[PIPE_STAGES-1].op;
  assign o_is_mext     = stage_q[PIPE_STAGES-1].is_mext;
  assign o_illegal     = stage_q[PIPE_STAGES-1].illegal;
  assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Bench for alu_control_pipe: three parameterisations driven by one shared stimulus.
//   u0: PIPE_STAGES=2, M_EXT=1, STRICT_F7=1
//   u1: PIPE_STAGES=4, M_EXT=0, STRICT_F7=0
//   u2: PIPE_STAGES=3, M_EXT=0, STRICT_F7=1
module tb_alu_control_pipe;
  import riscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       i_valid;
  logic [3:0] i_thread_id;
  logic [1:0] i_ALUctrl;
  logic [2:0] i_funct3;
  logic [6:0] i_funct7;
  logic       i_stall;
  logic       i_cnt_clr;

  logic        o0_valid, o1_valid, o2_valid;
  logic [3:0]  o0_tid, o1_tid, o2_tid;
  aluop_t      o0_op, o1_op, o2_op;
  logic        o0_mext, o1_mext, o2_mext;
  logic        o0_ill, o1_ill, o2_ill;
  logic [15:0] o0_cnt, o1_cnt, o2_cnt;

  alu_control_pipe #(.NUM_THREADS(16), .PIPE_STAGES(2), .M_EXT(1), .STRICT_F7(1)) u0 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_thread_id(i_thread_id),
    .i_ALUctrl(i_ALUctrl), .i_funct3(i_funct3), .i_funct7(i_funct7),
    .i_stall(i_stall), .i_cnt_clr(i_cnt_clr), .o_valid(o0_valid),
    .o_thread_id(o0_tid), .o_ALUOp(o0_op), .o_is_mext(o0_mext),
    .o_illegal(o0_ill), .o_illegal_cnt(o0_cnt));

  alu_control_pipe #(.NUM_THREADS(16), .PIPE_STAGES(4), .M_EXT(0), .STRICT_F7(0)) u1 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_thread_id(i_thread_id),
    .i_ALUctrl(i_ALUctrl), .i_funct3(i_funct3), .i_funct7(i_funct7),
    .i_stall(i_stall), .i_cnt_clr(i_cnt_clr), .o_valid(o1_valid),
    .o_thread_id(o1_tid), .o_ALUOp(o1_op), .o_is_mext(o1_mext),
    .o_illegal(o1_ill), .o_illegal_cnt(o1_cnt));

  alu_control_pipe #(.NUM_THREADS(16), .PIPE_STAGES(3), .M_EXT(0), .STRICT_F7(1)) u2 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_thread_id(i_thread_id),
    .i_ALUctrl(i_ALUctrl), .i_funct3(i_funct3), .i_funct7(i_funct7),
    .i_stall(i_stall), .i_cnt_clr(i_cnt_clr), .o_valid(o2_valid),
    .o_thread_id(o2_tid), .o_ALUOp(o2_op), .o_is_mext(o2_mext),
    .o_illegal(o2_ill), .o_illegal_cnt(o2_cnt));

  // Output bundles: {valid, tid[3:0], op[4:0], is_mext, illegal}
  logic [11:0] act_out [3];
  logic [15:0] act_cnt [3];
  assign act_out[0] = {o0_valid, o0_tid, o0_op, o0_mext, o0_ill};
  assign act_out[1] = {o1_valid, o1_tid, o1_op, o1_mext, o1_ill};
  assign act_out[2] = {o2_valid, o2_tid, o2_op, o2_mext, o2_ill};
  assign act_cnt[0] = o0_cnt;
  assign act_cnt[1] = o1_cnt;
  assign act_cnt[2] = o2_cnt;

  localparam int PS_A [3] = '{2, 4, 3};
  localparam bit MX_A [3] = '{1'b1, 1'b0, 1'b0};
  localparam bit ST_A [3] = '{1'b1, 1'b0, 1'b1};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0] op;
    logic       mext;
    logic       ill;
  } ref_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] tid;
    logic [1:0] ctrl;
    logic [2:0] f3;
    logic [6:0] f7;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  function automatic ref_t ref_dec(input logic [1:0] c, input logic [2:0] f3,
                                   input logic [6:0] f7, input bit mx, input bit st);
    ref_t r;
    logic [4:0] base [8];
    logic [4:0] mtab [8];
    base = '{ADD_OP, SLL_OP, SLT_OP, SLTU_OP, XOR_OP, SRL_OP, OR_OP, AND_OP};
    mtab = '{MUL_OP, MULH_OP, MULHSU_OP, MULHU_OP, DIV_OP, DIVU_OP, REM_OP, REMU_OP};
    r = '0;
    case (c)
      2'd0: r.op = ADD_OP;
      2'd1: r.op = SUB_OP;
      2'd3: r.op = PASS_OP;
      default: begin
        if (f7 == 7'h01 && mx) begin
          r.op = mtab[f3];
          r.mext = 1'b1;
        end else if (f7 == 7'h00) begin
          r.op = base[f3];
        end else if (f7 == 7'h20 || !st) begin
          r.op = (f3 == 3'd5) ? SRA_OP : base[f3];
        end else begin
          r.ill = 1'b1;
        end
      end
    endcase
    return r;
  endfunction

  // History of everything presented on unstalled edges since the last reset.
  logic [REQ_W-1:0] exp_q [$];
  logic [15:0]      m_cnt [3];

  function automatic logic [11:0] exp_out(input int k);
    req_t r;
    ref_t d;
    if (exp_q.size() < PS_A[k]) return 12'h0;
    r = exp_q[exp_q.size() - PS_A[k]];
    if (!r.valid) return 12'h0;
    d = ref_dec(r.ctrl, r.f3, r.f7, MX_A[k], ST_A[k]);
    return {1'b1, r.tid, d.op, d.mext, d.ill};
  endfunction

  always @(posedge clk) begin
    logic [11:0] o;
    req_t cur;
    if (reset) begin
      exp_q.delete();
      for (int k = 0; k < 3; k++) m_cnt[k] = 16'h0;
    end else begin
      if (!i_stall) begin
        cur = '{i_valid, i_thread_id, i_ALUctrl, i_funct3, i_funct7};
        exp_q.push_back(cur);
        if (exp_q.size() > 8) void'(exp_q.pop_front());
      end
      for (int k = 0; k < 3; k++) begin
        o = exp_out(k);
        if (i_cnt_clr) m_cnt[k] = 16'h0;
        else if (!i_stall && o[11] && o[0] && m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
      end
    end
  end

  // Per-cycle scoreboard compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("mon_u%0d_out", k), {20'h0, act_out[k]}, {20'h0, exp_out(k)});
        check($sformatf("mon_u%0d_cnt", k), {16'h0, act_cnt[k]}, {16'h0, m_cnt[k]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [3:0] tid, input logic [1:0] c,
                           input logic [2:0] f3, input logic [6:0] f7);
    i_valid = 1'b1; i_thread_id = tid; i_ALUctrl = c; i_funct3 = f3; i_funct7 = f7;
  endtask

  task automatic drive_idle();
    i_valid = 1'b0; i_thread_id = 4'h0; i_ALUctrl = 2'b00; i_funct3 = 3'h0; i_funct7 = 7'h0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; drive_idle(); tick(); reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] c;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] op0; logic m0; logic i0;
    logic [4:0] op1; logic m1; logic i1;
  } vec_t;

  vec_t tab [21];
  logic [3:0] got_q [$];

  initial begin
    tab[0]  = '{2'd0, 3'd5, 7'h7f, ADD_OP,    1'b0, 1'b0, ADD_OP,  1'b0, 1'b0};
    tab[1]  = '{2'd1, 3'd0, 7'h20, SUB_OP,    1'b0, 1'b0, SUB_OP,  1'b0, 1'b0};
    tab[2]  = '{2'd3, 3'd3, 7'h01, PASS_OP,   1'b0, 1'b0, PASS_OP, 1'b0, 1'b0};
    tab[3]  = '{2'd2, 3'd0, 7'h00, ADD_OP,    1'b0, 1'b0, ADD_OP,  1'b0, 1'b0};
    tab[4]  = '{2'd2, 3'd1, 7'h00, SLL_OP,    1'b0, 1'b0, SLL_OP,  1'b0, 1'b0};
    tab[5]  = '{2'd2, 3'd2, 7'h00, SLT_OP,    1'b0, 1'b0, SLT_OP,  1'b0, 1'b0};
    tab[6]  = '{2'd2, 3'd3, 7'h00, SLTU_OP,   1'b0, 1'b0, SLTU_OP, 1'b0, 1'b0};
    tab[7]  = '{2'd2, 3'd4, 7'h00, XOR_OP,    1'b0, 1'b0, XOR_OP,  1'b0, 1'b0};
    tab[8]  = '{2'd2, 3'd5, 7'h00, SRL_OP,    1'b0, 1'b0, SRL_OP,  1'b0, 1'b0};
    tab[9]  = '{2'd2, 3'd6, 7'h00, OR_OP,     1'b0, 1'b0, OR_OP,   1'b0, 1'b0};
    tab[10] = '{2'd2, 3'd7, 7'h00, AND_OP,    1'b0, 1'b0, AND_OP,  1'b0, 1'b0};
    tab[11] = '{2'd2, 3'd5, 7'h20, SRA_OP,    1'b0, 1'b0, SRA_OP,  1'b0, 1'b0};
    tab[12] = '{2'd2, 3'd0, 7'h20, ADD_OP,    1'b0, 1'b0, ADD_OP,  1'b0, 1'b0};
    tab[13] = '{2'd2, 3'd7, 7'h20, AND_OP,    1'b0, 1'b0, AND_OP,  1'b0, 1'b0};
    tab[14] = '{2'd2, 3'd0, 7'h01, MUL_OP,    1'b1, 1'b0, ADD_OP,  1'b0, 1'b0};
    tab[15] = '{2'd2, 3'd3, 7'h01, MULHU_OP,  1'b1, 1'b0, SLTU_OP, 1'b0, 1'b0};
    tab[16] = '{2'd2, 3'd4, 7'h01, DIV_OP,    1'b1, 1'b0, XOR_OP,  1'b0, 1'b0};
    tab[17] = '{2'd2, 3'd7, 7'h01, REMU_OP,   1'b1, 1'b0, AND_OP,  1'b0, 1'b0};
    tab[18] = '{2'd2, 3'd5, 7'h01, DIVU_OP,   1'b1, 1'b0, SRA_OP,  1'b0, 1'b0};
    tab[19] = '{2'd2, 3'd6, 7'h7f, NOP_OP,    1'b0, 1'b1, OR_OP,   1'b0, 1'b0};
    tab[20] = '{2'd2, 3'd5, 7'h7f, NOP_OP,    1'b0, 1'b1, SRA_OP,  1'b0, 1'b0};

    reset = 1'b1; i_stall = 1'b0; i_cnt_clr = 1'b0; drive_idle();
    repeat (3) tick();
    // Reset state, with stall and clear also asserted to show reset dominates.
    i_stall = 1'b1; i_cnt_clr = 1'b1; tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_u%0d_out", k), {20'h0, act_out[k]}, 32'h0);
      check($sformatf("reset_u%0d_cnt", k), {16'h0, act_cnt[k]}, 32'h0);
    end
    i_stall = 1'b0; i_cnt_clr = 1'b0; reset = 1'b0;
    chk_en = 1'b1;

    // Table vectors, one request at a time.
    for (int i = 0; i < 21; i++) begin
      logic [3:0] t;
      t = i[3:0];
      drive_req(t, tab[i].c, tab[i].f3, tab[i].f7);
      tick(); drive_idle();
      tick();
      check($sformatf("tab%0d_u0", i), {20'h0, act_out[0]},
            {20'h0, 1'b1, t, tab[i].op0, tab[i].m0, tab[i].i0});
      tick(); tick();
      check($sformatf("tab%0d_u1", i), {20'h0, act_out[1]},
            {20'h0, 1'b1, t, tab[i].op1, tab[i].m1, tab[i].i1});
    end

    // SRA through the two-stage pipe with tag 5.
    pulse_reset();
    drive_req(4'd5, 2'b10, 3'b101, 7'b0100000);
    tick(); drive_idle();
    check("sra_u0_early_valid", {31'h0, o0_valid}, 32'h0);
    tick();
    check("sra_u0_valid", {31'h0, o0_valid}, 32'h1);
    check("sra_u0_op", {27'h0, o0_op}, {27'h0, SRA_OP});
    check("sra_u0_tid", {28'h0, o0_tid}, 32'h5);

    // DIV with M enabled versus illegal with M disabled and strict funct7.
    pulse_reset();
    drive_req(4'd3, 2'b10, 3'b100, 7'b0000001);
    tick(); drive_idle();
    tick();
    check("div_u0_op", {27'h0, o0_op}, {27'h0, DIV_OP});
    check("div_u0_mext", {31'h0, o0_mext}, 32'h1);
    check("div_u2_cnt_before", {16'h0, o2_cnt}, 32'h0);
    tick();
    check("div_u2_out", {20'h0, act_out[2]}, {20'h0, 1'b1, 4'd3, NOP_OP, 1'b0, 1'b1});
    check("div_u2_cnt_after", {16'h0, o2_cnt}, 32'h1);

    // Eight back-to-back requests through u2 with a two-cycle stall in the middle.
    pulse_reset();
    got_q.delete();
    for (int n = 0; n < 22; n++) begin
      if (n < 4) begin
        i_stall = 1'b0; drive_req(n[3:0], 2'b00, 3'd0, 7'h0);
      end else if (n < 6) begin
        i_stall = 1'b1; drive_req(4'd15, 2'b11, 3'd0, 7'h0);
      end else if (n < 10) begin
        i_stall = 1'b0; drive_req(4'(n - 2), 2'b00, 3'd0, 7'h0);
      end else begin
        i_stall = 1'b0; drive_idle();
      end
      tick();
      if (!i_stall && o2_valid) got_q.push_back(o2_tid);
    end
    i_stall = 1'b0;
    check("b2b_count", got_q.size(), 32'd8);
    for (int i = 0; i < got_q.size(); i++) begin
      check($sformatf("b2b_tid%0d", i), {28'h0, got_q[i]}, i);
    end

    // Reset with two requests in flight in the four-stage pipe.
    pulse_reset();
    drive_req(4'd1, 2'b11, 3'd0, 7'h0); tick();
    drive_req(4'd2, 2'b11, 3'd0, 7'h0); tick();
    reset = 1'b1; drive_idle(); tick(); reset = 1'b0;
    check("rst_mid_u1_out", {20'h0, act_out[1]}, 32'h0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("rst_mid_u1_quiet%0d", c), {31'h0, o1_valid}, 32'h0);
    end
    drive_req(4'd9, 2'b11, 3'd0, 7'h0);
    for (int c = 1; c <= 3; c++) begin
      tick(); drive_idle();
      check($sformatf("post_rst_u1_lat%0d", c), {31'h0, o1_valid}, 32'h0);
    end
    tick();
    check("post_rst_u1_out", {20'h0, act_out[1]}, {20'h0, 1'b1, 4'd9, PASS_OP, 1'b0, 1'b0});

    // Randomized traffic checked by the scoreboard.
    for (int n = 0; n < 1500; n++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      if ($urandom_range(0, 1) == 1) drive_req(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                                               3'($urandom_range(0, 7)), f7);
      else drive_idle();
      i_stall   = ($urandom_range(0, 7) == 0);
      i_cnt_clr = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; i_stall = 1'b0; i_cnt_clr = 1'b0;

    // Saturation: push the counters to FFFE with an illegal stream, then past FFFF.
    pulse_reset();
    drive_req(4'd6, 2'b10, 3'd2, 7'h7f);
    repeat (65534) tick();
    drive_idle();
    repeat (5) tick();
    check("sat_u2_fffe", {16'h0, o2_cnt}, 32'hFFFE);
    check("sat_u0_fffe", {16'h0, o0_cnt}, 32'hFFFE);
    drive_req(4'd7, 2'b10, 3'd1, 7'h40);
    repeat (3) tick();
    drive_idle();
    repeat (5) tick();
    check("sat_u2_ffff", {16'h0, o2_cnt}, 32'hFFFF);
    check("sat_u0_ffff", {16'h0, o0_cnt}, 32'hFFFF);
    // Clear on the same edge that makes an illegal u2 result visible.
    drive_req(4'd8, 2'b10, 3'd0, 7'h11);
    tick(); drive_idle();
    tick();
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
    check("clr_u2_vis", {31'h0, o2_ill}, 32'h1);
    check("clr_u2_cnt", {16'h0, o2_cnt}, 32'h0);
    check("clr_u0_cnt", {16'h0, o0_cnt}, 32'h0);
    tick();
    check("clr_u2_cnt_hold", {16'h0, o2_cnt}, 32'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_control_pipe.md
ALU_CONTROL_PIPE -- requirements
Module: alu_control_pipe

Interface
REQ-001 Parameter NUM_THREADS, default 16, number of hart contexts tagged through the block (power of two, 2..32).
REQ-002 Parameter PIPE_STAGES, default 1, register stages from input to output (legal 1..4).
REQ-003 Parameter M_EXT, default 0, enables RV32M operation decode when 1.
REQ-004 Parameter STRICT_F7, default 1, flags non-canonical funct7 as illegal when 1.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 i_valid  input  1  decode request present this cycle.
REQ-008 i_thread_id  input  $clog2(NUM_THREADS)  hart tag of the request.
REQ-009 i_ALUctrl  input  2  00 add, 01 sub, 10 funct-decode, 11 pass operand B.
REQ-010 i_funct3  input  3  instruction funct3.
REQ-011 i_funct7  input  7  instruction funct7.
REQ-012 i_stall  input  1  freezes every pipeline stage.
REQ-013 i_cnt_clr  input  1  clears the illegal-op counter.
REQ-014 o_valid  output  1  decoded result valid.
REQ-015 o_thread_id  output  $clog2(NUM_THREADS)  tag matching o_ALUOp.
REQ-016 o_ALUOp  output  ALUOP_WIDTH  decoded operation code.
REQ-017 o_is_mext  output  1  result is an RV32M operation.
REQ-018 o_illegal  output  1  request decoded as illegal; o_ALUOp is zero.
REQ-019 o_illegal_cnt  output  16  saturating count of illegal results delivered.

Function
REQ-020 ALUctrl 00 SHALL yield ADD_OP, 01 SUB_OP, 11 PASS_OP, regardless of funct3/funct7.
REQ-021 ALUctrl 10, funct7 0000000: funct3 000..111 -> ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
REQ-022 ALUctrl 10, funct7 0100000: funct3 101 -> SRA; other funct3 -> base op per REQ-021 (ADD for 000).
REQ-023 ALUctrl 10, funct7 0000001 with M_EXT=1: funct3 000..111 -> MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, o_is_mext=1.
REQ-024 Any other funct7 (including 0000001 when M_EXT=0): STRICT_F7=1 -> o_illegal=1, o_ALUOp=0, o_is_mext=0; STRICT_F7=0 -> decode as funct7 0000000, except funct3 101 -> SRA.
REQ-025 With i_stall low every cycle, a request presented at cycle N SHALL appear on outputs at cycle N+PIPE_STAGES with its own thread_id.
REQ-026 i_stall high: all stage registers, o_* and o_illegal_cnt hold; i_valid/inputs that cycle are dropped.
REQ-027 Stages with valid=0 SHALL carry ALUOp=0, is_mext=0, illegal=0; o_* fields are zero whenever o_valid=0.
REQ-028 Back-to-back requests every cycle SHALL be accepted with no bubbles; throughput one per unstalled cycle.
REQ-029 o_illegal_cnt increments by 1 in the cycle a result with o_valid=1 and o_illegal=1 becomes visible on outputs, saturating at 16'hFFFF.
REQ-030 i_cnt_clr has priority over increment and over i_stall: counter becomes 0 next edge.

Reset
REQ-031 reset high at a rising edge SHALL zero every stage valid, o_valid, o_thread_id, o_ALUOp, o_is_mext, o_illegal, o_illegal_cnt; reset overrides i_stall and i_cnt_clr.
REQ-032 Reset mid-stream SHALL discard all in-flight requests; first post-reset request emerges PIPE_STAGES cycles after acceptance.

Structure
REQ-033 ALUOP_WIDTH and all *_OP constants, including new MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU codes and encodings unique from base ops, SHALL live in riscv_pkg.
REQ-034 Combinational decode SHALL be a sub-module alu_op_decode (ALUctrl, funct3, funct7 -> ALUOp, is_mext, illegal); alu_control_pipe holds the stage registers and counter.

Verification
REQ-035 PIPE_STAGES=2, no stall: ALUctrl=10, funct3=101, funct7=0100000, tid=5 at cycle 0 -> cycle 2 o_valid=1, o_ALUOp=SRA_OP, o_thread_id=5.
REQ-036 M_EXT=1: funct7=0000001, funct3=100 -> DIV_OP, o_is_mext=1; M_EXT=0, STRICT_F7=1 same stimulus -> o_illegal=1, o_ALUOp=0, counter 0->1.
REQ-037 PIPE_STAGES=3, 8 back-to-back requests tids 0..7, i_stall high 2 cycles mid-stream -> all 8 delivered in order, no duplicates or losses, outputs frozen during stall.
REQ-038 Counter preset to 16'hFFFE by forcing illegal stream: 3 more illegal results -> holds 16'hFFFF; i_cnt_clr coincident with an illegal result -> 0.
REQ-039 reset asserted with 2 requests in flight (PIPE_STAGES=4) -> all outputs zero next cycle, in-flight results never appear.
